dmem_responder: RTL and testbench

Memory-side responder for the CPU's MEM-stage data port. It accepts one read or write request at a time from the pipeline's memRead/memWrite/address/writeData signals and services it against an internal word array after a fixed, parameterised latency. While a request is in service it holds the pipeline with a stall signal, and it signals completion with a one-cycle ack.

---
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder for the MEM stage: one request in flight, fixed LATENCY to a one-cycle ack.
// stall holds the pipeline from acceptance until the ack cycle; re/we are ignored until the responder is idle again.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        stall,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [15:0]       mem_q [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic              op_we_q, op_we_d;
    logic              oor_q, oor_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;

    logic              req;
    logic              acc_oor;

    assign req     = re | we;
    assign acc_oor = (addr[15:ADDR_W] != '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_we_d = op_we_q;
        oor_d   = oor_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_we_d = we;
                    oor_d   = acc_oor;
                    err_d   = (re & we) | acc_oor;
                    idx_d   = addr[ADDR_W-1:0];
                    wdata_d = wdata;
                    count_d = CNT_INIT;
                    state_d = (LATENCY == 1) ? S_ACK : S_BUSY;
                end
            end
            S_BUSY: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data is captured on the edge entering ACK so it is already visible during the ack cycle.
    always_comb begin
        rdata_d = rdata_q;
        if (state_d == S_ACK && state_q != S_ACK && !op_we_d) begin
            rdata_d = oor_d ? 16'h0000 : mem_q[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= 4'd0;
            op_we_q <= 1'b0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_we_q <= op_we_d;
            oor_q   <= oor_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Writes commit at the end of the ack cycle; a reset in that cycle drops them.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_ACK && op_we_q && !oor_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack   = (state_q == S_ACK);
    assign err   = ack & err_q;
    assign stall = !rst & (((state_q == S_IDLE) & req) | (state_q == S_BUSY));
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a transaction-level model predicts stall/ack/err/rdata every cycle.
module tb_dmem_responder;

    localparam int LAT = 3;
    localparam int AW  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        ack;
    logic        stall;
    logic        err;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .re    (re),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .stall (stall),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: a request accepted in cycle T acks in cycle T+LAT.
    bit          mvalid = 1'b0;
    bit          m_pend = 1'b0;
    int          m_ack_at = 0;
    bit          m_we, m_oor, m_err;
    logic [9:0]  m_idx;
    logic [15:0] m_wd;
    logic [15:0] m_rdata = 16'h0000;
    logic [15:0] mm [1024];

    initial begin
        for (int i = 0; i < 1024; i++) mm[i] = 16'h0000;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pend  = 1'b0;
            m_rdata = 16'h0000;
            mvalid  = 1'b1;
        end else if (m_pend && cyc == m_ack_at) begin
            if (m_we) begin
                if (!m_oor) mm[m_idx] = m_wd;
            end else begin
                m_rdata = m_oor ? 16'h0000 : mm[m_idx];
            end
            m_pend = 1'b0;
        end else if (!m_pend && (re || we)) begin
            m_pend   = 1'b1;
            m_ack_at = cyc + LAT;
            m_we     = we;
            m_oor    = (addr[15:10] != 6'd0);
            m_err    = (re && we) || m_oor;
            m_idx    = addr[9:0];
            m_wd     = wdata;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            logic        e_ack, e_err, e_stall;
            logic [15:0] e_rdata;
            e_ack   = m_pend && (cyc == m_ack_at);
            e_err   = e_ack && m_err;
            e_stall = !rst && (m_pend ? (cyc < m_ack_at) : (re || we));
            e_rdata = (e_ack && !m_we) ? (m_oor ? 16'h0000 : mm[m_idx]) : m_rdata;
            chk("model_ack",   {15'd0, ack},   {15'd0, e_ack});
            chk("model_err",   {15'd0, err},   {15'd0, e_err});
            chk("model_stall", {15'd0, stall}, {15'd0, e_stall});
            chk("model_rdata", rdata, e_rdata);
        end
    end

    task automatic drive(input logic r, input logic rr, input logic ww,
                         input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst = r; re = rr; we = ww; addr = a; wdata = d;
    endtask

    task automatic idle1();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Issues a request and returns at the negedge of its ack cycle.
    task automatic xact(input logic rr, input logic ww, input logic [15:0] a, input logic [15:0] d);
        drive(1'b0, rr, ww, a, d);
        repeat (LAT) idle1();
        @(negedge clk);
    endtask

    initial begin
        int  nack, consec;
        logic prev;

        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("rst_ack",   {15'd0, ack},   16'h0000);
        chk("rst_err",   {15'd0, err},   16'h0000);
        chk("rst_stall", {15'd0, stall}, 16'h0000);
        chk("rst_rdata", rdata, 16'h0000);

        // Write BEEF to address 5
        drive(1'b0, 1'b0, 1'b1, 16'h0005, 16'hBEEF);
        @(negedge clk); chk("wr_stall_t0", {15'd0, stall}, 16'h0001);
        idle1(); @(negedge clk); chk("wr_stall_t1", {15'd0, stall}, 16'h0001);
        idle1(); @(negedge clk); chk("wr_stall_t2", {15'd0, stall}, 16'h0001);
        idle1(); @(negedge clk);
        chk("wr_ack",   {15'd0, ack},   16'h0001);
        chk("wr_err",   {15'd0, err},   16'h0000);
        chk("wr_stall", {15'd0, stall}, 16'h0000);
        chk("wr_rdata", rdata, 16'h0000);

        // Read-after-write
        drive(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
        @(negedge clk); chk("raw_stall", {15'd0, stall}, 16'h0001);
        idle1(); idle1(); idle1(); @(negedge clk);
        chk("raw_ack",   {15'd0, ack}, 16'h0001);
        chk("raw_rdata", rdata, 16'hBEEF);
        idle1(); idle1(); idle1(); @(negedge clk);
        chk("raw_hold", rdata, 16'hBEEF);

        // Request held continuously through ack cycles
        nack = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
            @(negedge clk);
            if (ack === 1'b1) begin
                nack++;
                if (prev) consec++;
            end
            prev = (ack === 1'b1);
        end
        chk("held_ack_count", 16'(nack), 16'd3);
        chk("held_no_consec", 16'(consec), 16'd0);
        idle1(); idle1();

        // Out-of-range write must not alias onto address 0
        xact(1'b0, 1'b1, 16'h0000, 16'h0F0F);
        xact(1'b0, 1'b1, 16'h0400, 16'h1234);
        chk("oor_wr_err", {15'd0, err}, 16'h0001);
        xact(1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("mem0_rdata", rdata, 16'h0F0F);
        chk("mem0_err",   {15'd0, err}, 16'h0000);
        xact(1'b1, 1'b0, 16'h8000, 16'h0000);
        chk("oor_rd_rdata", rdata, 16'h0000);
        chk("oor_rd_err",   {15'd0, err}, 16'h0001);

        // Highest legal address
        xact(1'b0, 1'b1, 16'h03FF, 16'hA5A5);
        chk("top_wr_err", {15'd0, err}, 16'h0000);
        xact(1'b1, 1'b0, 16'h03FF, 16'h0000);
        chk("top_rd_rdata", rdata, 16'hA5A5);

        // Simultaneous re/we acts as a write with err
        xact(1'b1, 1'b1, 16'h0003, 16'h00AA);
        chk("both_err", {15'd0, err}, 16'h0001);
        xact(1'b1, 1'b0, 16'h0003, 16'h0000);
        chk("both_rdata", rdata, 16'h00AA);

        // Reset mid-operation drops the pending write
        xact(1'b0, 1'b1, 16'h0007, 16'h1111);
        drive(1'b0, 1'b0, 1'b1, 16'h0007, 16'h5555);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("midrst_stall", {15'd0, stall}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            idle1(); @(negedge clk);
            chk("midrst_no_ack", {15'd0, ack}, 16'h0000);
        end
        xact(1'b1, 1'b0, 16'h0007, 16'h0000);
        chk("midrst_rdata", rdata, 16'h1111);

        idle1(); idle1();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
